// File: rtl/ram_rd_check.sv
// Read-side checker for the 2-port RAM test: aligns port-B requests with returned data,
// verifies data == addr + DATA_OFFSET, counts sweeps/errors. Define RAM_CHK_FIRST_ERR_EN to capture the first error.
module ram_rd_check #(
  parameter int RD_LATENCY  = 1,
  parameter int ADDR_LAST   = 126,
  parameter int DATA_OFFSET = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en_b,
  input  logic [6:0]  ram_addr_b,
  input  logic [7:0]  ram_rd_data,
  input  logic        clr_err,
  output logic        chk_busy,
  output logic        sweep_done,
  output logic        sweep_abort,
  output logic [15:0] pass_cnt,
  output logic [7:0]  err_cnt,
  output logic        err_flag,
  output logic [6:0]  first_err_addr,
  output logic [7:0]  first_err_data
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t state, state_nxt;
  logic [6:0] exp_next, exp_next_nxt;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [6:0]            addr_pipe [RD_LATENCY];

  logic       s_vld;
  logic [6:0] s_addr;
  logic [7:0] exp_data;
  logic       data_mis;
  logic       sample_err;
  logic       done_hit;
  logic       abort_hit;
  logic [7:0] err_base;
  logic       flag_base;

  // Delay enable/address so they line up with the RAM's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= ram_en_b;
      addr_pipe[0] <= ram_addr_b;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign s_vld    = vld_pipe[RD_LATENCY-1];
  assign s_addr   = addr_pipe[RD_LATENCY-1];
  assign exp_data = {1'b0, s_addr} + 8'(DATA_OFFSET);
  assign data_mis = (ram_rd_data != exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_next <= '0;
    end else begin
      state    <= state_nxt;
      exp_next <= exp_next_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    exp_next_nxt = exp_next;
    sample_err   = 1'b0;
    done_hit     = 1'b0;
    abort_hit    = 1'b0;
    if (s_vld) begin
      case (state)
        IDLE, DONE: begin
          if (s_addr == 7'd0) begin
            sample_err   = data_mis;
            state_nxt    = CHECK;
            exp_next_nxt = 7'd1;
          end
        end
        CHECK: begin
          if (s_addr == 7'd0 && exp_next != 7'd0) begin
            abort_hit    = 1'b1;
            sample_err   = data_mis;
            exp_next_nxt = 7'd1;
          end else begin
            // A sequence error and a data error on one sample count once.
            sample_err   = (s_addr != exp_next) | data_mis;
            exp_next_nxt = s_addr + 7'd1;
            if (s_addr == 7'(ADDR_LAST)) begin
              done_hit  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    chk_busy = (state == CHECK);
  end

  // The clear is applied first so an error in the same cycle lands on a zeroed count.
  assign err_base  = clr_err ? 8'd0 : err_cnt;
  assign flag_base = clr_err ? 1'b0 : err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_done  <= 1'b0;
      sweep_abort <= 1'b0;
      pass_cnt    <= '0;
      err_cnt     <= '0;
      err_flag    <= 1'b0;
    end else begin
      sweep_done  <= done_hit;
      sweep_abort <= abort_hit;
      if (done_hit && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      err_cnt  <= (sample_err && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
      err_flag <= flag_base | sample_err;
    end
  end

`ifdef RAM_CHK_FIRST_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (sample_err && !flag_base) begin
      first_err_addr <= s_addr;
      first_err_data <= ram_rd_data;
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_ram_rd_check.sv
// Drives one request stream into two checkers (read latency 1 and 2), each fed by its own
// delayed RAM data, and compares every cycle against a behavioural model of the checking rules.
module tb_ram_rd_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ram_en_b = 1'b0;
  logic [6:0] ram_addr_b = '0;
  logic [7:0] data_issue = '0;
  logic       clr_issue = 1'b0;

  // hist_*[k] is what the checker with latency k+1 sees as its aligned sample this cycle.
  logic       hist_v [2];
  logic [6:0] hist_a [2];
  logic [7:0] hist_d [2];
  logic       hist_c [2];

  logic        d_busy [2], d_done [2], d_abort [2], d_flag [2];
  logic [15:0] d_pass [2];
  logic [7:0]  d_errs [2], d_fd [2];
  logic [6:0]  d_fa [2];

  int checks = 0;
  int errors = 0;
  int abort_seen [2] = '{0, 0};

  int m_mode [2] = '{0, 0};
  int m_nxt [2] = '{0, 0};
  int m_pass [2] = '{0, 0};
  int m_errs [2] = '{0, 0};
  int m_flag [2] = '{0, 0};
  int m_done [2] = '{0, 0};
  int m_abort [2] = '{0, 0};
  int m_fa [2] = '{0, 0};
  int m_fd [2] = '{0, 0};

  always #5 clk = ~clk;

  ram_rd_check #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b),
    .ram_rd_data(hist_d[0]), .clr_err(hist_c[0]),
    .chk_busy(d_busy[0]), .sweep_done(d_done[0]), .sweep_abort(d_abort[0]),
    .pass_cnt(d_pass[0]), .err_cnt(d_errs[0]), .err_flag(d_flag[0]),
    .first_err_addr(d_fa[0]), .first_err_data(d_fd[0])
  );

  ram_rd_check #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b),
    .ram_rd_data(hist_d[1]), .clr_err(hist_c[1]),
    .chk_busy(d_busy[1]), .sweep_done(d_done[1]), .sweep_abort(d_abort[1]),
    .pass_cnt(d_pass[1]), .err_cnt(d_errs[1]), .err_flag(d_flag[1]),
    .first_err_addr(d_fa[1]), .first_err_data(d_fd[1])
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        hist_v[k] <= 1'b0; hist_a[k] <= '0; hist_d[k] <= '0; hist_c[k] <= 1'b0;
      end
    end else begin
      hist_v[0] <= ram_en_b;  hist_a[0] <= ram_addr_b;
      hist_d[0] <= data_issue; hist_c[0] <= clr_issue;
      hist_v[1] <= hist_v[0]; hist_a[1] <= hist_a[0];
      hist_d[1] <= hist_d[0]; hist_c[1] <= hist_c[0];
    end
  end

  // Model: mode 0 = waiting for address 0, 1 = sweeping, 2 = sweep finished.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_nxt[k] = 0; m_pass[k] = 0; m_errs[k] = 0; m_flag[k] = 0;
        m_done[k] = 0; m_abort[k] = 0; m_fa[k] = 0; m_fd[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int a, d, bad;
        a = int'(hist_a[k]);
        d = int'(hist_d[k]);
        bad = 0;
        m_done[k] = 0;
        m_abort[k] = 0;
        if (hist_c[k]) begin
          m_errs[k] = 0;
          m_flag[k] = 0;
        end
        if (hist_v[k]) begin
          if (m_mode[k] != 1) begin
            if (a == 0) begin
              bad = (d != a % 256);
              m_mode[k] = 1;
              m_nxt[k] = 1;
            end
          end else if (a == 0 && m_nxt[k] != 0) begin
            m_abort[k] = 1;
            bad = (d != 0);
            m_nxt[k] = 1;
          end else begin
            bad = (a != m_nxt[k]) || (d != a % 256);
            m_nxt[k] = (a + 1) % 128;
            if (a == 126) begin
              m_done[k] = 1;
              if (m_pass[k] < 65535) m_pass[k]++;
              m_mode[k] = 2;
            end
          end
        end
        if (bad != 0) begin
`ifdef RAM_CHK_FIRST_ERR_EN
          if (m_flag[k] == 0) begin
            m_fa[k] = a;
            m_fd[k] = d;
          end
`endif
          if (m_errs[k] < 255) m_errs[k]++;
          m_flag[k] = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d chk_busy", k + 1), int'(d_busy[k]), int'(m_mode[k] == 1));
      checkOutput($sformatf("dut%0d sweep_done", k + 1), int'(d_done[k]), m_done[k]);
      checkOutput($sformatf("dut%0d sweep_abort", k + 1), int'(d_abort[k]), m_abort[k]);
      checkOutput($sformatf("dut%0d pass_cnt", k + 1), int'(d_pass[k]), m_pass[k]);
      checkOutput($sformatf("dut%0d err_cnt", k + 1), int'(d_errs[k]), m_errs[k]);
      checkOutput($sformatf("dut%0d err_flag", k + 1), int'(d_flag[k]), m_flag[k]);
      checkOutput($sformatf("dut%0d first_err_addr", k + 1), int'(d_fa[k]), m_fa[k]);
      checkOutput($sformatf("dut%0d first_err_data", k + 1), int'(d_fd[k]), m_fd[k]);
      if (d_abort[k]) abort_seen[k]++;
    end
  end

  task automatic cyc(input bit en, input int addr, input int data, input bit clr);
    ram_en_b   = en;
    ram_addr_b = 7'(addr);
    data_issue = 8'(data);
    clr_issue  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ram_en_b = 1'b0;
    clr_issue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sweep lo..hi with data = address, optionally corrupting one word, skipping one address
  // and inserting an idle cycle before every gap_every-th request.
  task automatic applyStimulus(input int lo, input int hi, input int bad_addr, input int bad_val,
                               input int skip_addr, input int gap_every);
    int n = 0;
    for (int a = lo; a <= hi; a++) begin
      if (a != skip_addr) begin
        if (gap_every != 0 && (n % gap_every) == gap_every - 1) cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b1, a, (a == bad_addr) ? bad_val : a, 1'b0);
        n++;
      end
    end
  endtask

  task automatic check_both(input string tag, input int pass, input int errc, input int flag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s dut%0d pass", tag, k + 1), int'(d_pass[k]), pass);
      checkOutput($sformatf("%s dut%0d errs", tag, k + 1), int'(d_errs[k]), errc);
      checkOutput($sformatf("%s dut%0d flag", tag, k + 1), int'(d_flag[k]), flag);
    end
  endtask

  initial begin
    #1;
    rst_n = 1'b1;
    do_reset();
    check_both("reset", 0, 0, 0);
    checkOutput("reset busy", int'(d_busy[0]), 0);

    // Clean sweep: done pulse one cycle after the last sample, latency 2 one cycle later.
    applyStimulus(0, 126, -1, 0, -1, 0);
    cyc(1'b0, 0, 0, 1'b0);
    checkOutput("t1 dut1 done pulse", int'(d_done[0]), 1);
    checkOutput("t1 dut2 done early", int'(d_done[1]), 0);
    cyc(1'b0, 0, 0, 1'b0);
    checkOutput("t1 dut1 done end", int'(d_done[0]), 0);
    checkOutput("t1 dut2 done pulse", int'(d_done[1]), 1);
    idle(4);
    check_both("t1", 1, 0, 0);
    checkOutput("t1 busy after done", int'(d_busy[0]), 0);

    // Corrupted word at address 40.
    do_reset();
    applyStimulus(0, 126, 40, 8'hAA, -1, 0);
    idle(5);
    check_both("t2", 1, 1, 1);
`ifdef RAM_CHK_FIRST_ERR_EN
    checkOutput("t2 first addr", int'(d_fa[0]), 40);
    checkOutput("t2 first data", int'(d_fd[0]), 8'hAA);
`else
    checkOutput("t2 first addr tied", int'(d_fa[0]), 0);
    checkOutput("t2 first data tied", int'(d_fd[0]), 0);
`endif

    // Address jump 10 -> 12.
    do_reset();
    applyStimulus(0, 126, -1, 0, 11, 0);
    idle(5);
    check_both("t3", 1, 1, 1);

    // Restart after address 50, then a full sweep.
    do_reset();
    abort_seen[0] = 0;
    abort_seen[1] = 0;
    applyStimulus(0, 50, -1, 0, -1, 0);
    applyStimulus(0, 126, -1, 0, -1, 0);
    idle(5);
    check_both("t4", 1, 0, 0);
    checkOutput("t4 dut1 aborts", abort_seen[0], 1);
    checkOutput("t4 dut2 aborts", abort_seen[1], 1);

    // 300 corrupted words saturate the error count; then clear together with a mismatch.
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1'b1, i % 127, 8'hFF, 1'b0);
    idle(5);
    check_both("t5 sat", 2, 255, 1);
    cyc(1'b1, 46, 8'hEE, 1'b1);
    idle(5);
    check_both("t5 clr+err", 2, 1, 1);
`ifdef RAM_CHK_FIRST_ERR_EN
    checkOutput("t5 first addr", int'(d_fa[1]), 46);
    checkOutput("t5 first data", int'(d_fd[1]), 8'hEE);
`endif
    cyc(1'b0, 0, 0, 1'b1);
    idle(4);
    check_both("t5 clr", 2, 0, 0);

    // Latency-2 view with gaps, then a reset in the middle of a sweep.
    do_reset();
    applyStimulus(0, 126, -1, 0, -1, 4);
    idle(5);
    check_both("t6 gaps", 1, 0, 0);
    applyStimulus(0, 60, -1, 0, -1, 4);
    checkOutput("t6 busy before rst", int'(d_busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check_both("t6 in rst", 0, 0, 0);
    checkOutput("t6 dut2 busy in rst", int'(d_busy[1]), 0);
    ram_en_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 126, -1, 0, -1, 4);
    idle(5);
    check_both("t6 after rst", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
- Sits directly downstream of the dual-port RAM read port (port B) in the 2-port RAM test design.
- Watches the port-B enable, address and returned read data.
- Compares each returned word against the expected write pattern: data = address + DATA_OFFSET.
- Counts completed sweeps and mismatches, and drives a sticky error LED for on-board pass/fail indication.

Parameters:
- RD_LATENCY, 1, RAM read latency in clocks from address/enable to valid ram_rd_data; legal values 1..3.
- ADDR_LAST, 126, last address of a sweep; a checked sample at this address completes the sweep.
- DATA_OFFSET, 0, expected data = {1'b0, addr} + DATA_OFFSET, modulo 256.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- ram_en_b  input  1  RAM port-B enable, same cycle as ram_addr_b
- ram_addr_b  input  7  RAM port-B read address
- ram_rd_data  input  8  RAM port-B read data, valid RD_LATENCY cycles after en/addr
- clr_err  input  1  synchronous clear of err_cnt and err_flag
- chk_busy  output  1  high while state = CHECK
- sweep_done  output  1  one-cycle pulse on a completed sweep
- sweep_abort  output  1  one-cycle pulse when a sweep restarts before completion
- pass_cnt  output  16  completed sweeps, saturating at 16'hFFFF
- err_cnt  output  8  data/sequence errors, saturating at 8'hFF
- err_flag  output  1  sticky error indicator (LED)
- first_err_addr  output  7  address of first error (see Optional Feature)
- first_err_data  output  8  data read at first error (see Optional Feature)

Behaviour:
- Reset: all outputs 0. Pipeline valid bits 0. State IDLE. Expected-next-address register 0.
- Alignment pipeline:
  - ram_en_b and ram_addr_b are delayed RD_LATENCY stages.
  - The output is s_vld/s_addr, aligned with ram_rd_data.
  - All checking uses s_vld, s_addr and ram_rd_data in the same cycle.
- Expected data: exp = ({1'b0,s_addr} + DATA_OFFSET) mod 256.
- States: IDLE, CHECK, DONE.
- IDLE:
  - Ignores samples with s_addr != 0.
  - A sample with s_addr == 0 is checked, then the block enters CHECK with exp_next = 1.
- CHECK, per valid sample, in priority order:
  - s_addr == 0 with exp_next != 0: restart. Pulse sweep_abort, check the sample as address 0, exp_next = 1, stay in CHECK.
  - s_addr != exp_next: sequence error. err_cnt += 1, err_flag = 1, exp_next = s_addr + 1. The data is still compared, but at most one error is counted per sample.
  - Otherwise: if ram_rd_data != exp, data error; exp_next += 1.
  - If s_addr == ADDR_LAST: pulse sweep_done, pass_cnt += 1, go to DONE.
- DONE: a valid sample at s_addr 0 behaves exactly as in IDLE. Other samples are ignored.
- Gaps (s_vld low) hold state and exp_next in every state. They are not errors.
- Saturation: err_cnt holds at 255, pass_cnt holds at 65535. err_flag stays 1.
- clr_err:
  - Zeroes err_cnt and err_flag that cycle.
  - An error detected in the same cycle is applied after the clear, giving err_cnt = 1 and err_flag = 1.
  - It does not affect pass_cnt, the state, or first_err registers.
- Reset mid-sweep: immediate return to reset values. The pipeline is flushed, so in-flight samples are discarded.
- sweep_done and sweep_abort are never both high in the same cycle.

Optional Feature:
- Macro: RAM_CHK_FIRST_ERR_EN.
- Defined:
  - On the first error after reset or clr_err (when err_flag is 0), first_err_addr and first_err_data capture s_addr and ram_rd_data.
  - They hold until reset. clr_err re-arms capture but does not zero these registers.
- Undefined: first_err_addr and first_err_data are tied to 0, and no capture registers are built.

Test Plan:
1. RD_LATENCY=1. Sweep addresses 0..126 with data = address, en continuous → sweep_done pulses 1 cycle after the address-126 sample, pass_cnt=1, err_cnt=0, err_flag=0.
2. Same sweep with data at address 40 forced to 8'hAA → err_cnt=1, err_flag=1, pass_cnt=1; with the macro defined, first_err_addr=40 and first_err_data=8'hAA.
3. Sweep with addresses jumping 10→12 → one sequence error, err_cnt=1, and the sweep still completes at 126.
4. Restart at address 0 after address 50 → sweep_abort pulse, no pass_cnt change; the following full sweep gives pass_cnt=1.
5. 300 corrupted words → err_cnt saturates at 255. Then pulse clr_err in the same cycle as a mismatch → err_cnt=1, err_flag=1.
6. RD_LATENCY=2 with en gaps every 4th cycle → zero errors and pass_cnt=1. Assert rst_n at address 60 → all outputs 0, and after release the next sweep passes.
